// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the memory macro.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_arbiter_if #(
    parameter int WORD = 32,
    parameter int ADDR = 16
);
    // Fetch port
    logic            i_req;
    logic [ADDR-1:0] i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [WORD-1:0] i_rdata;

    // Data port
    logic            d_req;
    logic            d_we;
    logic [ADDR-1:0] d_addr;
    logic [WORD-1:0] d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [WORD-1:0] d_rdata;

    // Memory macro side
    logic [ADDR-1:0] mem_a;
    logic            mem_w;
    logic [WORD-1:0] mem_d;
    logic [WORD-1:0] mem_q;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_a, mem_w, mem_d,
        input  mem_q
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_a, mem_w, mem_d,
        output mem_q
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-port word memory
// between the fetch port and the data port, with a conflict counter.
module mem_arbiter #(
    parameter int WORD  = 32,
    parameter int ADDR  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {
        RSP_NONE = 2'd0,
        RSP_I    = 2'd1,
        RSP_D    = 2'd2
    } rsp_e;

    typedef enum logic {
        LG_I = 1'b0,
        LG_D = 1'b1
    } port_e;

    rsp_e             r_rsp;
    rsp_e             w_rsp_nxt;
    port_e            r_last_gnt;
    port_e            w_last_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic             w_gnt_i;
    logic             w_gnt_d;
    logic             w_conflict;
    logic [ADDR-1:0]  w_mem_a;
    logic             w_mem_w;
    logic [WORD-1:0]  w_mem_d;

    assign w_conflict = bus.i_req & bus.d_req;

    // Grant: single requester wins outright; on conflict the port
    // that did not win last time gets the memory. Nothing during reset.
    always_comb begin
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        if (!rst) begin
            if (w_conflict) begin
                if (r_last_gnt == LG_D) begin
                    w_gnt_i = 1'b1;
                end else begin
                    w_gnt_d = 1'b1;
                end
            end else if (bus.i_req) begin
                w_gnt_i = 1'b1;
            end else if (bus.d_req) begin
                w_gnt_d = 1'b1;
            end
        end
    end

    // Memory drive mux: idle cycles present a harmless read of word 0.
    always_comb begin
        w_mem_a = '0;
        w_mem_w = 1'b0;
        w_mem_d = '0;
        if (w_gnt_i) begin
            w_mem_a = bus.i_addr;
        end else if (w_gnt_d) begin
            w_mem_a = bus.d_addr;
            w_mem_w = bus.d_we;
            w_mem_d = bus.d_wdata;
        end
    end

    // Next response owner and round-robin pointer; stores return nothing.
    always_comb begin
        w_rsp_nxt  = RSP_NONE;
        w_last_nxt = r_last_gnt;
        if (w_gnt_i) begin
            w_rsp_nxt  = RSP_I;
            w_last_nxt = LG_I;
        end else if (w_gnt_d) begin
            w_last_nxt = LG_D;
            if (!bus.d_we) begin
                w_rsp_nxt = RSP_D;
            end
        end
    end

    // State: response owner, last winner and saturating conflict count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp      <= RSP_NONE;
            r_last_gnt <= LG_D;
            r_cnt      <= '0;
        end else begin
            r_rsp      <= w_rsp_nxt;
            r_last_gnt <= w_last_nxt;
            if (w_conflict && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.i_gnt    = w_gnt_i;
    assign bus.d_gnt    = w_gnt_d;
    assign bus.mem_a    = w_mem_a;
    assign bus.mem_w    = w_mem_w;
    assign bus.mem_d    = w_mem_d;
    assign bus.i_rvalid = (r_rsp == RSP_I);
    assign bus.d_rvalid = (r_rsp == RSP_D);
    assign bus.i_rdata  = bus.mem_q;
    assign bus.d_rdata  = bus.mem_q;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, saturation run on a narrow
// counter instance, and randomized traffic against a reference model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst2;
    logic [15:0] cnt;
    logic [3:0]  cnt2;

    mem_arbiter_if #(.WORD(32), .ADDR(16)) bus ();
    mem_arbiter_if #(.WORD(32), .ADDR(16)) bus2 ();

    mem_arbiter #(.WORD(32), .ADDR(16), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .conflict_cnt (cnt)
    );

    mem_arbiter #(.WORD(32), .ADDR(16), .CNT_W(4)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .bus          (bus2),
        .conflict_cnt (cnt2)
    );

    // Synchronous memory macro: write at the edge, Q registered.
    logic [31:0] mem [0:65535];
    logic [31:0] q;
    always @(posedge clk) begin
        if (bus.mem_w) mem[bus.mem_a] <= bus.mem_d;
        q <= mem[bus.mem_a];
    end
    assign bus.mem_q  = q;
    assign bus2.mem_q = 32'h0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [31:0] dwd;
        logic        eig;
        logic        edg;
        logic        eir;
        logic        edr;
        logic        dchk;
        logic [31:0] edata;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic drive(input logic r, input logic ir, input logic [15:0] ia,
                         input logic dr, input logic we, input logic [15:0] da,
                         input logic [31:0] wd);
        rst         = r;
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = we;
        bus.d_addr  = da;
        bus.d_wdata = wd;
    endtask

    // Random-phase reference state
    logic [31:0] ref_mem [16];
    logic        turn_i;
    int          pk;
    logic [31:0] pdata;
    logic [15:0] cnt_m;
    logic        ip, dp, dwe_r, i_new, d_new, r_r, gi, gd;
    logic [15:0] ia_r, da_r;
    logic [31:0] dwd_r;

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        rst2         = 1'b1;
        bus2.i_req   = 1'b1;
        bus2.i_addr  = 16'h0;
        bus2.d_req   = 1'b1;
        bus2.d_we    = 1'b0;
        bus2.d_addr  = 16'h0;
        bus2.d_wdata = 32'h0;

        // rst ir ia dr we da wd | ig dg ir dr dchk data cnt
        tbl.push_back('{1,1,16'h30,1,1,16'h10,32'hDEADBEEF, 0,0,0,0,0,0,0});
        tbl.push_back('{1,1,16'h30,1,1,16'h10,32'hDEADBEEF, 0,0,0,0,0,0,0});
        tbl.push_back('{0,1,16'h30,1,1,16'h10,32'hDEADBEEF, 1,0,0,0,0,0,0});
        tbl.push_back('{0,0,16'h0,1,1,16'h10,32'hDEADBEEF, 0,1,1,0,0,0,1});
        tbl.push_back('{0,1,16'h10,0,0,16'h0,32'h0, 1,0,0,0,0,0,1});
        tbl.push_back('{0,0,16'h0,0,0,16'h0,32'h0, 0,0,1,0,1,32'hDEADBEEF,1});
        tbl.push_back('{0,0,16'h0,0,0,16'h0,32'h0, 0,0,0,0,0,0,1});
        tbl.push_back('{0,0,16'h0,1,1,16'hFFFF,32'h12345678, 0,1,0,0,0,0,1});
        tbl.push_back('{0,0,16'h0,1,0,16'hFFFF,32'h0, 0,1,0,0,0,0,1});
        tbl.push_back('{0,0,16'h0,0,0,16'h0,32'h0, 0,0,0,1,1,32'h12345678,1});
        tbl.push_back('{0,0,16'h0,1,1,16'h1,32'h111, 0,1,0,0,0,0,1});
        tbl.push_back('{0,0,16'h0,1,1,16'h2,32'h222, 0,1,0,0,0,0,1});
        tbl.push_back('{1,0,16'h0,0,0,16'h0,32'h0, 0,0,0,0,0,0,1});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 1,0,0,0,0,0,0});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 0,1,1,0,1,32'h111,1});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 1,0,0,1,1,32'h222,2});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 0,1,1,0,1,32'h111,3});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 1,0,0,1,1,32'h222,4});
        tbl.push_back('{0,1,16'h1,1,0,16'h2,32'h0, 0,1,1,0,1,32'h111,5});
        tbl.push_back('{0,0,16'h0,0,0,16'h0,32'h0, 0,0,0,1,1,32'h222,6});
        tbl.push_back('{0,0,16'h0,1,0,16'h1,32'h0, 0,1,0,0,0,0,6});
        tbl.push_back('{1,0,16'h0,1,0,16'h2,32'h0, 0,0,0,1,1,32'h111,6});
        tbl.push_back('{0,0,16'h0,0,0,16'h0,32'h0, 0,0,0,0,0,0,0});

        @(posedge clk);
        foreach (tbl[k]) begin
            vec_t v;
            logic [15:0] ea;
            logic        ew;
            logic [31:0] ed;
            v = tbl[k];
            @(negedge clk);
            drive(v.rst, v.ireq, v.iaddr, v.dreq, v.dwe, v.daddr, v.dwd);
            #1;
            ea = 16'h0; ew = 1'b0; ed = 32'h0;
            if (v.eig) begin
                ea = v.iaddr;
            end else if (v.edg) begin
                ea = v.daddr; ew = v.dwe; ed = v.dwd;
            end
            chk($sformatf("row%0d i_gnt", k), bus.i_gnt, v.eig);
            chk($sformatf("row%0d d_gnt", k), bus.d_gnt, v.edg);
            chk($sformatf("row%0d i_rvalid", k), bus.i_rvalid, v.eir);
            chk($sformatf("row%0d d_rvalid", k), bus.d_rvalid, v.edr);
            chk($sformatf("row%0d mem_a", k), bus.mem_a, ea);
            chk($sformatf("row%0d mem_w", k), bus.mem_w, ew);
            chk($sformatf("row%0d mem_d", k), bus.mem_d, ed);
            chk($sformatf("row%0d cnt", k), cnt, v.ecnt);
            if (v.dchk) begin
                if (v.eir) chk($sformatf("row%0d i_rdata", k), bus.i_rdata, v.edata);
                else       chk($sformatf("row%0d d_rdata", k), bus.d_rdata, v.edata);
            end
        end

        // Narrow counter saturates at 15 under sustained conflict.
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        rst2 = 1'b0;
        #1;
        chk("sat cnt0", cnt2, 0);
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("sat cnt%0d", k), cnt2, (k > 15) ? 15 : k);
            chk($sformatf("sat onegnt%0d", k), bus2.i_gnt ^ bus2.d_gnt, 1);
        end

        // Preload words 0..15 through the data port.
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            ref_mem[a] = $urandom;
            drive(0, 0, 0, 1, 1, 16'(a), ref_mem[a]);
            #1;
            chk($sformatf("pre d_gnt%0d", a), bus.d_gnt, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("pre cnt", cnt, 0);

        turn_i = 1'b1;
        pk     = 0;
        pdata  = 32'h0;
        cnt_m  = 16'h0;
        ip = 0; dp = 0; dwe_r = 0; ia_r = 0; da_r = 0; dwd_r = 0;
        i_new = 1; d_new = 1;

        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            r_r = ($urandom_range(0, 39) == 0);
            if (i_new || $urandom_range(0, 9) == 0) begin
                ip   = 1'($urandom_range(0, 1));
                ia_r = 16'($urandom_range(0, 15));
            end
            if (d_new || $urandom_range(0, 9) == 0) begin
                dp    = 1'($urandom_range(0, 1));
                dwe_r = 1'($urandom_range(0, 1));
                da_r  = 16'($urandom_range(0, 15));
                dwd_r = $urandom;
            end
            drive(r_r, ip, ia_r, dp, dwe_r, da_r, dwd_r);
            #1;
            gi = 0; gd = 0;
            if (!r_r) begin
                if (ip && dp) begin
                    gi = turn_i; gd = !turn_i;
                end else begin
                    gi = ip; gd = dp;
                end
            end
            chk($sformatf("rnd%0d i_gnt", c), bus.i_gnt, gi);
            chk($sformatf("rnd%0d d_gnt", c), bus.d_gnt, gd);
            chk($sformatf("rnd%0d mem_w", c), bus.mem_w, gd && dwe_r);
            chk($sformatf("rnd%0d i_rvalid", c), bus.i_rvalid, pk == 1);
            chk($sformatf("rnd%0d d_rvalid", c), bus.d_rvalid, pk == 2);
            if (pk == 1) chk($sformatf("rnd%0d i_rdata", c), bus.i_rdata, pdata);
            if (pk == 2) chk($sformatf("rnd%0d d_rdata", c), bus.d_rdata, pdata);
            chk($sformatf("rnd%0d cnt", c), cnt, cnt_m);

            pk = 0;
            if (gi) begin
                pk = 1; pdata = ref_mem[ia_r[3:0]];
            end else if (gd && !dwe_r) begin
                pk = 2; pdata = ref_mem[da_r[3:0]];
            end
            if (gd && dwe_r) ref_mem[da_r[3:0]] = dwd_r;
            if (r_r) turn_i = 1'b1;
            else if (gi) turn_i = 1'b0;
            else if (gd) turn_i = 1'b1;
            if (r_r) cnt_m = 16'h0;
            else if (ip && dp && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'h1;
            i_new = gi || !ip;
            d_new = gd || !dp;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
